// File: rtl/lcd_cmd_host.sv
// Host-side driver for the LCD controller: queues a command script, issues it over cmd/cmd_valid/busy,
// captures the IRAM write-back into a local 64x8 store and tracks checksum, write count and protocol errors.
module lcd_cmd_host #(
    parameter int FIFO_DEPTH = 16,
    parameter int GUARD_CYC  = 2,
    parameter int TIMEOUT    = 1023
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] prog_cmd,
    input  logic       prog_valid,
    output logic       prog_ready,
    input  logic       start,
    output logic [3:0] cmd,
    output logic       cmd_valid,
    input  logic       busy,
    input  logic       done,
    input  logic       IRAM_valid,
    input  logic [5:0] IRAM_A,
    input  logic [7:0] IRAM_D,
    input  logic [5:0] rb_addr,
    output logic [7:0] rb_data,
    output logic [13:0] checksum,
    output logic [6:0] wr_count,
    output logic [6:0] fifo_count,
    output logic       err_order,
    output logic       err_timeout,
    output logic       finished
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_ISSUE, S_GUARD, S_CAPTURE, S_FINISH
    } state_t;

    state_t        state, state_nxt;
    logic [3:0]    fifo_mem [FIFO_DEPTH];
    logic [7:0]    store [64];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic          push, pop, tmo_set, to_hit, last_term;
    logic [2:0]    gcnt;
    logic [15:0]   tcnt;
    logic [5:0]    exp_addr;

    assign prog_ready = (fifo_count < 7'(FIFO_DEPTH));
    assign push       = prog_valid && prog_ready;
    assign to_hit     = (tcnt == 16'(TIMEOUT));
    assign finished   = (state == S_FINISH);

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        tmo_set   = 1'b0;
        case (state)
            S_IDLE:  if (start) state_nxt = S_WAIT;
            S_WAIT: begin
                if (to_hit) begin
                    state_nxt = S_FINISH;
                    tmo_set   = 1'b1;
                end else if (done) begin
                    state_nxt = S_FINISH;
                end else if (!busy && fifo_count != 7'd0) begin
                    state_nxt = S_ISSUE;
                    pop       = 1'b1;
                end
            end
            S_ISSUE: state_nxt = S_GUARD;
            S_GUARD: begin
                if (done)
                    state_nxt = S_FINISH;
                else if (gcnt == 3'(GUARD_CYC - 1))
                    state_nxt = last_term ? S_CAPTURE : S_WAIT;
            end
            S_CAPTURE: begin
                if (to_hit) begin
                    state_nxt = S_FINISH;
                    tmo_set   = 1'b1;
                end else if (done) begin
                    state_nxt = S_FINISH;
                end
            end
            S_FINISH: state_nxt = S_FINISH;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            gcnt        <= 3'd0;
            tcnt        <= 16'd0;
            err_timeout <= 1'b0;
        end else begin
            state <= state_nxt;
            gcnt  <= (state == S_GUARD) ? gcnt + 3'd1 : 3'd0;
            // Only consecutive waiting cycles count; any state change restarts the window.
            if (state_nxt != state)
                tcnt <= 16'd0;
            else if ((state == S_WAIT && busy) || state == S_CAPTURE)
                tcnt <= tcnt + 16'd1;
            else
                tcnt <= 16'd0;
            if (tmo_set)
                err_timeout <= 1'b1;
        end
    end

    // Pop happens on the WAIT->ISSUE edge so cmd/cmd_valid are registered for the ISSUE cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= 7'd0;
            cmd        <= 4'd0;
            cmd_valid  <= 1'b0;
            last_term  <= 1'b0;
        end else begin
            cmd_valid <= pop;
            if (pop) begin
                cmd       <= fifo_mem[rd_ptr];
                last_term <= (fifo_mem[rd_ptr] == 4'd0);
                rd_ptr    <= rd_ptr + 1'b1;
            end
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 7'd1;
                2'b01:   fifo_count <= fifo_count - 7'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= prog_cmd;
        if (IRAM_valid)
            store[IRAM_A] <= IRAM_D;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_addr  <= 6'd0;
            checksum  <= 14'd0;
            wr_count  <= 7'd0;
            err_order <= 1'b0;
            rb_data   <= 8'd0;
        end else begin
            rb_data <= store[rb_addr];
            if (IRAM_valid) begin
                checksum <= checksum + {6'd0, IRAM_D};
                exp_addr <= exp_addr + 6'd1;
                if (wr_count != 7'd127)
                    wr_count <= wr_count + 7'd1;
                if (IRAM_A != exp_addr || wr_count >= 7'd64)
                    err_order <= 1'b1;
            end
        end
    end
endmodule

// File: doc/lcd_cmd_host.md
# lcd_cmd_host

Host-side driver for the LCD image-processing controller. It queues a command script pushed by the testbench or system controller and issues it over the controller's `cmd`/`cmd_valid`/`busy` handshake. It captures the image the controller writes back on the IRAM write port into a local 64x8 store, and reports checksum, write count and protocol errors. It sits opposite the LCD controller, and both share the same clock and reset.

## Interface
- `FIFO_DEPTH`, 16: command queue depth, a power of two, 2..64.
- `GUARD_CYC`, 2: cycles after an issue during which `busy` is ignored, 1..7.
- `TIMEOUT`, 1023: max consecutive cycles waiting on `busy` low or `done` before the timeout error fires.
- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `prog_cmd`  in  4  command opcode to enqueue (0 = write-back/terminal, 1..11 = ops).
- `prog_valid`  in  1  enqueue request.
- `prog_ready`  out  1  queue not full.
- `start`  in  1  single-cycle pulse; leave IDLE.
- `cmd`  out  4  command to the LCD controller.
- `cmd_valid`  out  1  command strobe, exactly one cycle per command.
- `busy`  in  1  controller busy.
- `done`  in  1  controller finished write-back.
- `IRAM_valid`  in  1  write strobe from the controller.
- `IRAM_A`  in  6  write address.
- `IRAM_D`  in  8  write data.
- `rb_addr`  in  6  capture-store readback address.
- `rb_data`  out  8  registered readback data, one-cycle latency.
- `checksum`  out  14  sum of all captured bytes.
- `wr_count`  out  7  number of IRAM writes, saturating at 127.
- `fifo_count`  out  7  current queue occupancy.
- `err_order`  out  1  sticky: out-of-order or excess write.
- `err_timeout`  out  1  sticky: wait exceeded `TIMEOUT`.
- `finished`  out  1  run complete.

## Operation
- States: IDLE, WAIT, ISSUE, GUARD, CAPTURE, FINISH.
- IDLE → WAIT on `start`. Pushes are accepted in every state.
- WAIT → ISSUE when `busy`=0 and the queue is non-empty. If the queue is empty, stay in WAIT with `cmd_valid`=0.
- ISSUE, one cycle: pop the head, drive `cmd`=head and `cmd_valid`=1, then go to GUARD.
- GUARD lasts `GUARD_CYC` cycles with `busy` ignored. It then goes to CAPTURE if the issued cmd was 0, otherwise to WAIT.
- CAPTURE: no further commands issue; the queue is retained. Go to FINISH on `done`=1.
- `done`=1 in WAIT or GUARD also goes to FINISH.
- FINISH is terminal: `finished`=1 until reset.
- Timeout counter:
  - Counts cycles in WAIT with `busy`=1 and cycles in CAPTURE.
  - Clears on every state change.
  - Reaching `TIMEOUT` sets `err_timeout` and forces FINISH.
- Capture is active in every state:
  - On `IRAM_valid`, store `IRAM_D` at `IRAM_A`, add it to `checksum` (14-bit, wraps), increment `wr_count` and increment the expected address.
  - Expected address starts at 0.
  - Set `err_order` if `IRAM_A` ≠ expected, or if the write is the 65th or later. The write is still stored.
- Queue:
  - `prog_ready` = (`fifo_count` < `FIFO_DEPTH`), from registered state.
  - A push while full is dropped.
  - Simultaneous push and pop when not full keeps `fifo_count` unchanged.
  - When full, the pop proceeds and the push is refused that cycle.
  - Read and write pointers wrap modulo `FIFO_DEPTH`.
- Opcodes 12..15 are issued unchanged; the host does not filter them.

## Timing
- Reset values:
  - `cmd`=0, `cmd_valid`=0, `prog_ready`=1, `rb_data`=0, `checksum`=0, `wr_count`=0, `fifo_count`=0.
  - `err_order`=0, `err_timeout`=0, `finished`=0.
  - State IDLE, expected address 0, queue empty.
  - Capture store contents are not reset.
- `start` in cycle t: WAIT at t+1. With `busy`=0 and the queue non-empty at t+1, `cmd_valid`=1 at t+2.
- Minimum spacing between consecutive `cmd_valid` pulses is `GUARD_CYC`+2 cycles.
- `cmd` holds its value after `cmd_valid` falls.
- `checksum`, `wr_count` and `err_order` update on the edge after the `IRAM_valid` cycle.
- `rb_data` = store[`rb_addr`] one cycle later. A same-cycle write to that address returns the old data.
- `reset` mid-run clears all control state immediately, asynchronously.

## Test plan
- Push 3,4,5,0; `start`; the stub drops `busy` 3 cycles after each `cmd_valid` → `cmd_valid` pulses carry 3,4,5,0 in order with spacing ≥4; then CAPTURE.
- After cmd 0, the stub writes addresses 0..63 with D=A, then asserts `done` → `checksum`=2016, `wr_count`=64, `err_order`=0, `finished`=1; `rb_addr`=17 gives `rb_data`=17.
- Push 17 commands with `FIFO_DEPTH`=16 while in IDLE → `prog_ready`=0 after 16; 17th dropped; `fifo_count`=16.
- Writes to addresses 0,1,3 → `err_order`=1 after the third write; `wr_count`=3; `checksum`=sum of the data.
- Hold `busy`=1 after `start` with `TIMEOUT`=20 → `err_timeout`=1 and `finished`=1 at cycle 21 after entering WAIT.
- Assert `reset` while in GUARD with 5 entries queued → all outputs return to reset values; a later `start` with the queue empty issues nothing.
